fetch_stage: RTL

Instruction fetch stage directly upstream of the decode stage. It issues word-aligned requests on the instruction memory port and realigns mixed 16/32-bit RISC-V instructions through a halfword buffer. Each cycle it presents one instruction with its pc and any fetch exception on the `f` fields that decode samples. It obeys the pipeline stall and redirects on jump, mret or trap.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 71 +++++++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its halfword buffer.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [3:0]  except_instr_access_fault = 4'd1;
  localparam int          BUF_HW = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2,
    S_FAULT   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exception;
    logic [3:0]  ecause;
    logic [31:0] etval;
  } fetch_out_type;

  localparam fetch_out_type FETCH_BUBBLE = '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR,
                                             exception: 1'b0, ecause: 4'h0, etval: 32'h0};

endpackage

// File: rtl/fetch_buffer.sv
// Three-halfword realignment buffer. The incoming word is merged combinationally so a
// response can be consumed in the same cycle it arrives.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_app,
  input  logic        i_app_hi_only,
  input  logic [31:0] i_app_word,
  input  logic        i_consume,
  output logic        o_ready,
  output logic        o_is16,
  output logic        o_space,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_tail_pc
);

  logic [BUF_HW-1:0][15:0] r_hw;
  logic [2:0]              r_cnt;
  logic [31:0]             r_pc;
  logic [BUF_HW+1:0][15:0] w_m;
  logic [2:0]              w_mcnt;
  logic [2:0]              w_take;
  logic [2:0]              w_rem;

  always_comb begin
    w_m    = '0;
    w_mcnt = r_cnt;
    for (int i = 0; i < BUF_HW; i++) begin
      if (3'(i) < r_cnt) w_m[i] = r_hw[i];
    end
    if (i_app) begin
      if (i_app_hi_only) begin
        w_m[r_cnt] = i_app_word[31:16];
        w_mcnt     = r_cnt + 3'd1;
      end else begin
        w_m[r_cnt]        = i_app_word[15:0];
        w_m[r_cnt + 3'd1] = i_app_word[31:16];
        w_mcnt            = r_cnt + 3'd2;
      end
    end
  end

  assign o_is16    = (w_m[0][1:0] != 2'b11);
  assign o_ready   = (w_mcnt >= 3'd2) || ((w_mcnt == 3'd1) && o_is16);
  assign o_instr   = {w_m[1], w_m[0]};
  assign w_take    = (i_consume && o_ready) ? (o_is16 ? 3'd1 : 3'd2) : 3'd0;
  assign w_rem     = w_mcnt - w_take;
  assign o_space   = (w_rem <= 3'd1);
  assign o_pc      = r_pc;
  assign o_tail_pc = r_pc + {28'h0, r_cnt, 1'b0};

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_cnt <= 3'd0;
      r_hw  <= '0;
      r_pc  <= {i_flush_pc[31:1], 1'b0};
    end else begin
      r_cnt <= w_rem;
      r_pc  <= r_pc + {28'h0, w_take, 1'b0};
      for (int i = 0; i < BUF_HW; i++) begin
        r_hw[i] <= w_m[3'(i) + w_take];
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word requests to imem, 16/32-bit realignment, registered f_* outputs.
// imem handshake: imem_valid/imem_addr are held stable until the cycle imem_ready=1; data and err are valid only then.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_valid,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_err,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  output logic         f_valid,
  output logic [31:0]  f_pc,
  output logic [31:0]  f_instr,
  output logic         f_exception,
  output logic [3:0]   f_ecause,
  output logic [31:0]  f_etval,
  output fetch_state_t dbg_state
);

  fetch_state_t  r_state, w_state_nxt;
  logic [31:0]   r_addr, w_addr_nxt;
  logic [31:0]   r_pend, w_pend_nxt;
  logic [31:0]   r_fault_pc, w_fault_pc_nxt;
  logic          r_drop, w_drop_nxt;
  logic          r_fault_pend, w_fault_pend_nxt;
  fetch_out_type r_f, w_f_nxt;

  logic        w_resp, w_accept, w_consume;
  logic        w_buf_ready, w_buf_is16, w_buf_space;
  logic [31:0] w_buf_instr, w_buf_pc, w_buf_tail_pc, w_flush_pc, w_redir_addr;

  assign w_resp       = (r_state == S_REQ) && imem_ready;
  assign w_accept     = w_resp && !redirect && !imem_err;
  assign w_consume    = !stall && !redirect;
  assign w_flush_pc   = rst ? RESET_PC : redirect_pc;
  assign w_redir_addr = {redirect_pc[31:2], 2'b00};

  fetch_buffer u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (redirect),
    .i_flush_pc   (w_flush_pc),
    .i_app        (w_accept),
    .i_app_hi_only(r_drop),
    .i_app_word   (imem_rdata),
    .i_consume    (w_consume),
    .o_ready      (w_buf_ready),
    .o_is16       (w_buf_is16),
    .o_space      (w_buf_space),
    .o_instr      (w_buf_instr),
    .o_pc         (w_buf_pc),
    .o_tail_pc    (w_buf_tail_pc)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_pend_nxt       = r_pend;
    w_drop_nxt       = r_drop;
    w_fault_pend_nxt = r_fault_pend;
    w_fault_pc_nxt   = r_fault_pc;
    w_f_nxt          = r_f;
    if (w_accept) begin
      w_addr_nxt = r_addr + 32'd4;
      w_drop_nxt = 1'b0;
    end
    if (redirect) begin
      w_drop_nxt       = redirect_pc[1];
      w_fault_pend_nxt = 1'b0;
      w_f_nxt          = FETCH_BUBBLE;
      // An unanswered request must finish at its old address before the new one goes out.
      if ((r_state == S_REQ || r_state == S_DISCARD) && !imem_ready) begin
        w_state_nxt = S_DISCARD;
        w_pend_nxt  = w_redir_addr;
      end else begin
        w_state_nxt = S_REQ;
        w_addr_nxt  = w_redir_addr;
      end
    end else begin
      case (r_state)
        S_IDLE:    if (w_buf_space) w_state_nxt = S_REQ;
        S_REQ: begin
          if (imem_ready) begin
            if (imem_err) begin
              w_state_nxt      = S_FAULT;
              w_fault_pend_nxt = 1'b1;
              w_fault_pc_nxt   = w_buf_tail_pc;
            end else begin
              w_state_nxt = w_buf_space ? S_REQ : S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (imem_ready) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = r_pend;
          end
        end
        default: ;
      endcase
      if (!stall) begin
        if (w_buf_ready) begin
          w_f_nxt = '{valid: 1'b1, pc: w_buf_pc,
                      instr: w_buf_is16 ? {16'h0, w_buf_instr[15:0]} : w_buf_instr,
                      exception: 1'b0, ecause: 4'h0, etval: 32'h0};
        end else if (r_state == S_FAULT && r_fault_pend) begin
          w_f_nxt = '{valid: 1'b1, pc: r_fault_pc, instr: NOP_INSTR, exception: 1'b1,
                      ecause: except_instr_access_fault, etval: r_fault_pc};
          w_fault_pend_nxt = 1'b0;
        end else begin
          w_f_nxt = FETCH_BUBBLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= {RESET_PC[31:2], 2'b00};
      r_pend       <= 32'h0;
      r_drop       <= RESET_PC[1];
      r_fault_pend <= 1'b0;
      r_fault_pc   <= 32'h0;
      r_f          <= FETCH_BUBBLE;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_pend       <= w_pend_nxt;
      r_drop       <= w_drop_nxt;
      r_fault_pend <= w_fault_pend_nxt;
      r_fault_pc   <= w_fault_pc_nxt;
      r_f          <= w_f_nxt;
    end
  end

  assign imem_valid  = (r_state == S_REQ) || (r_state == S_DISCARD);
  assign imem_addr   = r_addr;
  assign f_valid     = r_f.valid;
  assign f_pc        = r_f.pc;
  assign f_instr     = r_f.instr;
  assign f_exception = r_f.exception;
  assign f_ecause    = r_f.ecause;
  assign f_etval     = r_f.etval;
  assign dbg_state   = r_state;

endmodule
